// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with debounce, key-event handshake and a 4-digit BCD entry register.
// Optional auto-repeat while a single key is held: define KEYPAD_REPEAT_EN.
`timescale 1ns/1ps

module keypad_scan_ctrl #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 40,
   parameter int REPEAT_RATE    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] kp_row,
   output logic [3:0] kp_col,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [3:0] key_code,
   output logic       key_overrun,
   output logic [3:0] bcd_data_0,
   output logic [3:0] bcd_data_1,
   output logic [3:0] bcd_data_2,
   output logic [3:0] bcd_data_3,
   output logic       entry_valid
);

   localparam int SlotW = $clog2(SCAN_DIV);
   localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);

   // Debounce and repeat counters share one width wide enough for either limit.
   localparam int CntMaxA = (DEBOUNCE_SCANS > REPEAT_DELAY) ? DEBOUNCE_SCANS : REPEAT_DELAY;
   localparam int CntMax  = (CntMaxA > REPEAT_RATE) ? CntMaxA : REPEAT_RATE;
   localparam int CntW    = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] DebTarget = CntW'(DEBOUNCE_SCANS);
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CntW-1:0] RepDelay = CntW'(REPEAT_DELAY);
   localparam logic [CntW-1:0] RepRate  = CntW'(REPEAT_RATE);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_HELD,
      S_LOCK
   } state_t;

   logic [3:0]       rowMeta_q;
   logic [3:0]       rowSync_q;
   logic [SlotW-1:0] slot_q;
   logic [1:0]       colIdx_q;
   logic [15:0]      snap_q;
   logic [15:0]      prevSnap_q;
   logic [15:0]      stable_q;
   logic [15:0]      snapFull;
   logic [CntW-1:0]  match_q, match_d;
   logic             scanDone_q;
   logic             slotEnd;
   logic             colEnd;

   state_t           state_q, state_d;
   logic [3:0]       heldCode_q, heldCode_d;
`ifdef KEYPAD_REPEAT_EN
   logic [CntW-1:0]  rep_q, rep_d;
`endif
   logic [4:0]       keyCount;
   logic [3:0]       keyIdx;
   logic             emit;

   logic             keyValid_q, keyValid_d;
   logic [3:0]       keyCode_q, keyCode_d;
   logic             overrun_q, overrun_d;
   logic             accept;

   logic [3:0][3:0]  bcd_q, bcd_d;
   logic [2:0]       digits_q, digits_d;

   assign slotEnd = (slot_q == SlotLast);
   assign colEnd  = slotEnd && (colIdx_q == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         rowMeta_q <= 4'hF;
         rowSync_q <= 4'hF;
      end else begin
         rowMeta_q <= kp_row;
         rowSync_q <= rowMeta_q;
      end
   end

   // The snapshot with the current column's pressed rows merged in.
   always_comb begin
      snapFull = snap_q;
      for (int r = 0; r < 4; r++) begin
         snapFull[{r[1:0], colIdx_q}] = ~rowSync_q[r];
      end
   end

   always_comb begin
      if (snapFull == prevSnap_q) begin
         match_d = (match_q >= DebTarget) ? match_q : match_q + CntW'(1);
      end else begin
         match_d = CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q     <= '0;
         colIdx_q   <= 2'd0;
         snap_q     <= '0;
         prevSnap_q <= '0;
         stable_q   <= '0;
         match_q    <= '0;
         scanDone_q <= 1'b0;
      end else begin
         scanDone_q <= colEnd;
         if (slotEnd) begin
            slot_q   <= '0;
            colIdx_q <= colIdx_q + 2'd1;
            snap_q   <= snapFull;
         end else begin
            slot_q <= slot_q + SlotW'(1);
         end
         if (colEnd) begin
            prevSnap_q <= snapFull;
            match_q    <= match_d;
            if (match_d >= DebTarget) begin
               stable_q <= snapFull;
            end
         end
      end
   end

   assign kp_col = ~(4'b0001 << colIdx_q);

   // Bit index of a pressed key equals its key value, so the last set bit is the code.
   always_comb begin
      keyCount = '0;
      keyIdx   = '0;
      for (int i = 0; i < 16; i++) begin
         if (stable_q[i]) begin
            keyCount = keyCount + 5'd1;
            keyIdx   = i[3:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         heldCode_q <= '0;
`ifdef KEYPAD_REPEAT_EN
         rep_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         heldCode_q <= heldCode_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q      <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      heldCode_d = heldCode_q;
      emit       = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d      = rep_q;
`endif
      if (scanDone_q) begin
         case (state_q)
            S_IDLE: begin
               if (keyCount == 5'd1) begin
                  emit       = 1'b1;
                  heldCode_d = keyIdx;
                  state_d    = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                  rep_d      = RepDelay;
`endif
               end else if (keyCount != 5'd0) begin
                  state_d = S_LOCK;
               end
            end
            S_HELD: begin
               if ((keyCount == 5'd1) && (keyIdx == heldCode_q)) begin
`ifdef KEYPAD_REPEAT_EN
                  if (rep_q <= CntW'(1)) begin
                     emit  = 1'b1;
                     rep_d = RepRate;
                  end else begin
                     rep_d = rep_q - CntW'(1);
                  end
`endif
               end else begin
                  state_d = (keyCount == 5'd0) ? S_IDLE : S_LOCK;
`ifdef KEYPAD_REPEAT_EN
                  rep_d   = '0;
`endif
               end
            end
            S_LOCK: begin
               if (keyCount == 5'd0) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // A new event may load in the same cycle the pending one is accepted.
   assign accept = keyValid_q && key_ready;

   always_comb begin
      keyValid_d = keyValid_q;
      keyCode_d  = keyCode_q;
      overrun_d  = 1'b0;
      if (accept) begin
         keyValid_d = 1'b0;
      end
      if (emit) begin
         if (!keyValid_q || accept) begin
            keyValid_d = 1'b1;
            keyCode_d  = keyIdx;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_comb begin
      bcd_d    = bcd_q;
      digits_d = digits_q;
      if (emit) begin
         if (keyIdx < 4'd10) begin
            bcd_d    = {bcd_q[2:0], keyIdx};
            digits_d = (digits_q == 3'd4) ? 3'd4 : digits_q + 3'd1;
         end else if (keyIdx == 4'd10) begin
            bcd_d    = {4'd0, bcd_q[3:1]};
            digits_d = (digits_q == 3'd0) ? 3'd0 : digits_q - 3'd1;
         end else if (keyIdx == 4'd11) begin
            bcd_d    = '0;
            digits_d = 3'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         keyValid_q <= 1'b0;
         keyCode_q  <= '0;
         overrun_q  <= 1'b0;
         bcd_q      <= '0;
         digits_q   <= '0;
      end else begin
         keyValid_q <= keyValid_d;
         keyCode_q  <= keyCode_d;
         overrun_q  <= overrun_d;
         bcd_q      <= bcd_d;
         digits_q   <= digits_d;
      end
   end

   assign key_valid   = keyValid_q;
   assign key_code    = keyCode_q;
   assign key_overrun = overrun_q;
   assign bcd_data_0  = bcd_q[0];
   assign bcd_data_1  = bcd_q[1];
   assign bcd_data_2  = bcd_q[2];
   assign bcd_data_3  = bcd_q[3];
   assign entry_valid = (digits_q != 3'd0);

endmodule
